// File: rtl/sobel_edge_core.sv
// Sobel edge detector: 3x3 window from two line buffers, L1 gradient |Gx|+|Gy|, 5-cycle fixed latency.
// Optional: define SOBEL_DIR_EN to add post_img_dir, the quantised gradient direction.
module sobel_edge_core #(
    parameter int                DATA_W     = 8,
    parameter int                IMG_W      = 640,
    parameter logic [DATA_W-1:0] BORDER_VAL = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] thresh,
    input  logic              mode,
    input  logic              pre_img_vsync,
    input  logic              pre_img_hsync,
    input  logic              pre_img_valid,
    input  logic [DATA_W-1:0] pre_img_data,
    output logic              post_img_vsync,
    output logic              post_img_hsync,
    output logic              post_img_valid,
    output logic [DATA_W-1:0] post_img_data,
`ifdef SOBEL_DIR_EN
    output logic [1:0]        post_img_dir,
`endif
    output logic              line_ovf
);
    localparam int COL_W  = $clog2(IMG_W + 1);
    localparam int ADDR_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int SUM_W  = DATA_W + 2;
    localparam int G_W    = DATA_W + 3;
    localparam int S_W    = DATA_W + 4;
    localparam logic [COL_W-1:0] IMG_W_C = COL_W'(IMG_W);

    function automatic logic [SUM_W-1:0] wsum_f(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [DATA_W-1:0] c);
        wsum_f = {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    function automatic logic [G_W-1:0] abs_f(input logic signed [G_W-1:0] v);
        logic [G_W-1:0] u;
        u     = v;
        abs_f = u[G_W-1] ? (~u + {{(G_W-1){1'b0}}, 1'b1}) : u;
    endfunction

    logic              vsync_d_r, valid_d_r;
    logic [COL_W-1:0]  col_r;
    logic [1:0]        row_r;
    logic              vs_rise_s, eol_s, in_range_s, border_s;
    logic [COL_W-1:0]  col_eff_s;
    logic [1:0]        row_eff_s;
    logic [ADDR_W-1:0] addr_s;

    logic [DATA_W-1:0] lb0_mem [IMG_W];
    logic [DATA_W-1:0] lb1_mem [IMG_W];
    logic [DATA_W-1:0] rd0_r, rd1_r, pix_r;
    logic              wr1_en_r;
    logic [ADDR_W-1:0] wr1_addr_r;
    logic [DATA_W-1:0] c1_top_r, c1_mid_r, c1_bot_r, c0_top_r, c0_mid_r, c0_bot_r;

    logic [2:0]        sync_sr_r [5];
    logic              border_sr_r [4];
    logic [SUM_W-1:0]  sxr_r, sxl_r, syb_r, syt_r;
    logic signed [G_W-1:0] gx_r, gy_r;
    logic [S_W-1:0]    mag_r;
    logic [DATA_W-1:0] sat_s, bin_s, res_s;

    // Frame-start and end-of-line decode; a vsync rise forces the current pixel to (row 0, col 0)
    always_comb begin
        vs_rise_s = pre_img_vsync & ~vsync_d_r;
        eol_s     = ~pre_img_valid & valid_d_r;
        if (vs_rise_s) begin
            col_eff_s = '0;
            row_eff_s = 2'd0;
        end else begin
            col_eff_s = col_r;
            row_eff_s = row_r;
        end
        in_range_s = (col_eff_s < IMG_W_C);
        if (in_range_s) begin
            addr_s = col_eff_s[ADDR_W-1:0];
        end else begin
            addr_s = '0;
        end
        border_s = (row_eff_s < 2'd2) | (col_eff_s < COL_W'(2)) | ~in_range_s;
    end

    // Column/row position counters and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d_r <= 1'b0;
            valid_d_r <= 1'b0;
            col_r     <= '0;
            row_r     <= 2'd0;
            line_ovf  <= 1'b0;
        end else begin
            vsync_d_r <= pre_img_vsync;
            valid_d_r <= pre_img_valid;
            if (pre_img_valid) begin
                col_r <= in_range_s ? (col_eff_s + COL_W'(1)) : col_eff_s;
                row_r <= row_eff_s;
            end else if (vs_rise_s) begin
                col_r <= '0;
                row_r <= 2'd0;
            end else if (eol_s) begin
                col_r <= '0;
                row_r <= (row_r == 2'd2) ? 2'd2 : (row_r + 2'd1);
            end
            if (pre_img_valid && !in_range_s) begin
                line_ovf <= 1'b1;
            end
        end
    end

    // Line buffers: lb0 holds row r-1, lb1 holds row r-2 (refilled one cycle later from lb0's read data)
    always_ff @(posedge clk) begin
        if (pre_img_valid) begin
            rd0_r <= lb0_mem[addr_s];
            rd1_r <= lb1_mem[addr_s];
            if (in_range_s) begin
                lb0_mem[addr_s] <= pre_img_data;
            end
        end
        if (wr1_en_r) begin
            lb1_mem[wr1_addr_r] <= rd0_r;
        end
    end

    // Window shift: newest column is {rd1_r, rd0_r, pix_r}, older columns c1 (c-1) and c0 (c-2)
    always_ff @(posedge clk) begin
        if (rst) begin
            wr1_en_r   <= 1'b0;
            wr1_addr_r <= '0;
            pix_r      <= '0;
            c1_top_r   <= '0;
            c1_mid_r   <= '0;
            c1_bot_r   <= '0;
            c0_top_r   <= '0;
            c0_mid_r   <= '0;
            c0_bot_r   <= '0;
        end else begin
            wr1_en_r   <= pre_img_valid & in_range_s;
            wr1_addr_r <= addr_s;
            if (pre_img_valid) begin
                pix_r    <= pre_img_data;
                c1_top_r <= rd1_r;
                c1_mid_r <= rd0_r;
                c1_bot_r <= pix_r;
                c0_top_r <= c1_top_r;
                c0_mid_r <= c1_mid_r;
                c0_bot_r <= c1_bot_r;
            end
        end
    end

    // Sync and border qualifiers travel alongside the data for exactly five stages
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) sync_sr_r[i] <= 3'b000;
            for (int i = 0; i < 4; i++) border_sr_r[i] <= 1'b0;
        end else begin
            sync_sr_r[0]   <= {pre_img_vsync, pre_img_hsync, pre_img_valid};
            border_sr_r[0] <= border_s;
            for (int i = 1; i < 5; i++) sync_sr_r[i] <= sync_sr_r[i-1];
            for (int i = 1; i < 4; i++) border_sr_r[i] <= border_sr_r[i-1];
        end
    end

    assign post_img_vsync = sync_sr_r[4][2];
    assign post_img_hsync = sync_sr_r[4][1];
    assign post_img_valid = sync_sr_r[4][0];

`ifdef SOBEL_DIR_EN
    logic [G_W-1:0] ax_r, ay_r;
    logic           sgn_diff_r;
    logic [1:0]     dir_s;
`endif

    // Stages 2-4: weighted column/row sums, signed gradients, L1 magnitude
    always_ff @(posedge clk) begin
        if (rst) begin
            sxr_r <= '0;
            sxl_r <= '0;
            syb_r <= '0;
            syt_r <= '0;
            gx_r  <= '0;
            gy_r  <= '0;
            mag_r <= '0;
`ifdef SOBEL_DIR_EN
            ax_r       <= '0;
            ay_r       <= '0;
            sgn_diff_r <= 1'b0;
`endif
        end else begin
            sxr_r <= wsum_f(rd1_r, rd0_r, pix_r);
            sxl_r <= wsum_f(c0_top_r, c0_mid_r, c0_bot_r);
            syb_r <= wsum_f(c0_bot_r, c1_bot_r, pix_r);
            syt_r <= wsum_f(c0_top_r, c1_top_r, rd1_r);
            gx_r  <= $signed({1'b0, sxr_r}) - $signed({1'b0, sxl_r});
            gy_r  <= $signed({1'b0, syb_r}) - $signed({1'b0, syt_r});
            mag_r <= {1'b0, abs_f(gx_r)} + {1'b0, abs_f(gy_r)};
`ifdef SOBEL_DIR_EN
            ax_r       <= abs_f(gx_r);
            ay_r       <= abs_f(gy_r);
            sgn_diff_r <= gx_r[G_W-1] ^ gy_r[G_W-1];
`endif
        end
    end

    // Stage 5 result select: invalid -> 0, border/overflow -> BORDER_VAL, else threshold or saturate
    always_comb begin
        if (mag_r > {4'b0000, {DATA_W{1'b1}}}) begin
            sat_s = {DATA_W{1'b1}};
        end else begin
            sat_s = mag_r[DATA_W-1:0];
        end
        if (mag_r > {4'b0000, thresh}) begin
            bin_s = {DATA_W{1'b1}};
        end else begin
            bin_s = {DATA_W{1'b0}};
        end
        if (!sync_sr_r[3][0]) begin
            res_s = {DATA_W{1'b0}};
        end else if (border_sr_r[3]) begin
            res_s = BORDER_VAL;
        end else if (mode) begin
            res_s = sat_s;
        end else begin
            res_s = bin_s;
        end
`ifdef SOBEL_DIR_EN
        dir_s = 2'd0;
        if (!sync_sr_r[3][0] || border_sr_r[3]) begin
            dir_s = 2'd0;
        end else if ({1'b0, ax_r} >= {ay_r, 1'b0}) begin
            dir_s = 2'd0;
        end else if ({1'b0, ay_r} >= {ax_r, 1'b0}) begin
            dir_s = 2'd1;
        end else if (!sgn_diff_r) begin
            dir_s = 2'd2;
        end else begin
            dir_s = 2'd3;
        end
`endif
    end

    // Stage 5 output register
    always_ff @(posedge clk) begin
        if (rst) begin
            post_img_data <= {DATA_W{1'b0}};
`ifdef SOBEL_DIR_EN
            post_img_dir  <= 2'd0;
`endif
        end else begin
            post_img_data <= res_s;
`ifdef SOBEL_DIR_EN
            post_img_dir  <= dir_s;
`endif
        end
    end
endmodule

// File: doc/sobel_edge_core.md
# sobel_edge_core

Parametrised Sobel edge detector for the grayscale video pipeline: accepts a vsync/hsync/valid pixel stream, builds its own 3x3 window from two internal line buffers, and computes the L1 gradient |Gx|+|Gy|. Output is either a thresholded binary edge map or the saturated magnitude, selected at run time. It is the drop-in successor to the fixed 8-bit sqrt-based detector. It is generic in pixel width and line length, reports line-length overflow, and can optionally output a quantised gradient direction.

## Interface
- DATA_W, 8, pixel width in bits (>=4)
- IMG_W, 640, maximum pixels per line; sets line-buffer depth
- BORDER_VAL, {DATA_W{1'b1}}, value output for border and overflow pixels
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- thresh  in  DATA_W  binary-mode threshold; sampled every cycle
- mode  in  1  0 = binary edge map, 1 = saturated magnitude
- pre_img_vsync  in  1  frame sync, active high; rising edge marks frame start
- pre_img_hsync  in  1  line sync; delayed alongside data
- pre_img_valid  in  1  pixel qualifier
- pre_img_data  in  DATA_W  pixel
- post_img_vsync / post_img_hsync / post_img_valid  out  1  input syncs delayed by LAT
- post_img_data  out  DATA_W  edge result
- line_ovf  out  1  sticky: a line exceeded IMG_W pixels

## Operation
- Counters:
  - col counts valid pixels from 0. It resets on the cycle after valid falls (end of line) and on the vsync rising edge. It saturates at IMG_W.
  - row is a 2-bit counter saturating at 2. It increments at each end of line and clears on the vsync rising edge.
- Line buffers:
  - Two IMG_W x DATA_W RAMs with synchronous read, addressed by col.
  - Writes occur only when valid and col<IMG_W.
  - A 3-column shift register holds rows r-2, r-1, r.
- Window: the output at input (r,c) is the gradient centred on (r-1,c-1), so the output image is offset by one row and one column.
- Border: if r<2 or c<2, the output is BORDER_VAL. For pixels with col>=IMG_W, the output is BORDER_VAL and line_ovf is set; it clears only on rst.
- Arithmetic:
  - Gx = (p13+2p23+p33)-(p11+2p21+p31) and Gy = (p31+2p32+p33)-(p11+2p12+p13), each signed DATA_W+3 bits.
  - S = |Gx|+|Gy|, unsigned DATA_W+4 bits.
- Output:
  - mode 0: all-ones if S > thresh (zero-extended), else 0. S == thresh gives 0.
  - mode 1: min(S, 2^DATA_W-1).
- mode and thresh are sampled at pipeline stage 5, so a change affects pixels entering stage 5 from the next cycle.
- When valid=0, post_img_data is 0.

## Timing
- LAT = 5 clk from pre_* to post_*, fixed, with no stalls and no backpressure.
- Pipeline stages:
  1. RAM read / window shift
  2. partial sums
  3. Gx, Gy
  4. abs + sum
  5. threshold / saturate register
- Sync signals go through a 5-deep shift register, so pulse widths are preserved exactly.
- Reset values: all post_* = 0, line_ovf = 0, col = row = 0, pipeline qualifiers = 0. RAM contents are not cleared; the r<2 border masks stale data.
- Reset mid-frame: outputs go to 0 on the next edge. Pixels arriving after reset without a vsync are treated as row 0, so they are border.
- Simultaneous vsync rise and valid: the pixel is col 0, row 0.
- Back-to-back lines need at least 1 cycle of valid=0 between them.

## Configuration
- SOBEL_DIR_EN defined: adds output post_img_dir [1:0], aligned with post_img_data and reset to 0.
  - 0 = |Gx| >= 2|Gy|
  - 1 = |Gy| >= 2|Gx|
  - 2 = diagonal with Gx·Gy > 0
  - 3 = diagonal with Gx·Gy < 0
  - Border, overflow and invalid pixels give 0.
- SOBEL_DIR_EN undefined: the port and its logic are absent; everything else is identical.

## Test plan
All tests use DATA_W=8 and IMG_W=8.
- Flat 8x8 frame of 100, mode 0, thresh 10: rows 0–1 and cols 0–1 = 255, all other pixels = 0. post_img_valid equals pre_img_valid delayed exactly 5 clk.
- Vertical step, cols 0–3 = 0 and cols 4–7 = 50, mode 1: interior output cols 4 and 5 = 200, other interior pixels = 0. Repeat with step 100: cols 4 and 5 = 255 (saturated, S=400).
- Threshold edge, step 50 (S=200), mode 0: thresh 200 gives 0 at cols 4–5; thresh 199 gives 255.
- 10-pixel line with IMG_W=8: output cols 8–9 = 255 and line_ovf rises, staying 1 across later frames until rst. The following line is processed normally.
- rst asserted mid-row 4: next-cycle outputs = 0. Resumed pixels without vsync give border 255 for the first two rows. A subsequent vsync restarts normal processing.
- With SOBEL_DIR_EN, horizontal step (rows 0–3 = 0, rows 4–7 = 80): interior edge pixels give post_img_dir = 1 and flat pixels give 0.
